// File: rtl/keypad_scanner_pkg.sv
// Shared types, default parameters and helper functions for the matrix-keypad scanner.
package keypad_pkg;

  localparam int DEF_ROWS           = 4;
  localparam int DEF_COLS           = 4;
  localparam int DEF_COL_CYCLES     = 100000;
  localparam int DEF_SETTLE_CYCLES  = 8;
  localparam int DEF_DEBOUNCE_SCANS = 3;
  localparam int MAX_KEYS           = 256;

  typedef enum logic [1:0] {S_DRIVE, S_SAMPLE, S_DWELL} scan_state_t;

  typedef enum logic [1:0] {KEYS_NONE, KEYS_ONE, KEYS_MULTI} key_class_t;

  function automatic int key_index(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

  function automatic key_class_t key_class(input logic [MAX_KEYS-1:0] bits);
    int n;
    n = 0;
    for (int i = 0; i < MAX_KEYS; i++) n += int'(bits[i]);
    if (n == 0)      return KEYS_NONE;
    else if (n == 1) return KEYS_ONE;
    else             return KEYS_MULTI;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-report bundle; master is the scanner side.
interface keypad_scanner_if
  import keypad_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int KEYW = $clog2(ROWS*COLS)
);
  logic [ROWS-1:0] Rows;
  logic [COLS-1:0] Cols;
  logic [KEYW-1:0] keyValue;
  logic            keyPressed;
  logic            keyEvent;
  logic            multiKey;

  modport master (input Rows, output Cols, output keyValue, output keyPressed,
                  output keyEvent, output multiKey);
  modport slave  (output Rows, input Cols, input keyValue, input keyPressed,
                  input keyEvent, input multiKey);
endinterface

// File: rtl/keypad_debounce.sv
// Whole-frame debouncer: accepts a frame after DEBOUNCE_SCANS identical scans and classifies it.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
  parameter int KEYW           = $clog2(ROWS*COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] frame,
  input  logic                 frame_end,
  output logic [KEYW-1:0]      key_value,
  output logic                 key_pressed,
  output logic                 key_event,
  output logic                 multi_key
);
  localparam int NKEYS = ROWS * COLS;
  localparam int SW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

  logic [NKEYS-1:0] prev_q, acc_q;
  logic [SW-1:0]    stable_q, stable_nxt;
  logic             accept;
  key_class_t       cls;
  logic [KEYW-1:0]  idx;

  always_comb begin
    stable_nxt = '0;
    if (frame == prev_q)
      stable_nxt = (stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1);
    accept = frame_end && (stable_nxt == STABLE_MAX) && (frame != acc_q);
    cls    = key_class(MAX_KEYS'(frame));
    idx    = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (frame[r*COLS+c]) idx = KEYW'(key_index(r, c, COLS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      acc_q       <= '0;
      stable_q    <= '0;
      key_value   <= '0;
      key_pressed <= 1'b0;
      key_event   <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (frame_end) begin
        prev_q   <= frame;
        stable_q <= stable_nxt;
      end
      // A zero or multi-key frame keeps the last reported index.
      if (accept) begin
        acc_q <= frame;
        case (cls)
          KEYS_ONE: begin
            key_value   <= idx;
            key_pressed <= 1'b1;
            key_event   <= 1'b1;
            multi_key   <= 1'b0;
          end
          KEYS_MULTI: begin
            key_pressed <= 1'b0;
            multi_key   <= 1'b1;
          end
          default: begin
            key_pressed <= 1'b0;
            multi_key   <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner: row synchroniser, column scan FSM and frame capture feeding the debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int COL_CYCLES     = DEF_COL_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
  parameter int KEYW           = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);
  localparam int NKEYS = ROWS * COLS;
  localparam int CW    = $clog2(COL_CYCLES);
  localparam int KW    = $clog2(COLS);

  logic [ROWS-1:0]  rows_s1, rows_s2, rows_act;
  scan_state_t      state, state_nxt;
  logic [CW-1:0]    c_q, c_nxt;
  logic [KW-1:0]    k_q, k_nxt;
  logic             sample_en, frame_end;
  logic [COLS-1:0]  cols_q, col_drive;
  logic [NKEYS-1:0] frame_q;

  assign rows_act = ~rows_s2;
  assign kp.Cols  = cols_q;

  always_comb begin
    state_nxt = state;
    c_nxt     = c_q + CW'(1);
    k_nxt     = k_q;
    sample_en = 1'b0;
    frame_end = 1'b0;
    case (state)
      S_DRIVE:  if (c_q == CW'(SETTLE_CYCLES - 1)) state_nxt = S_SAMPLE;
      S_SAMPLE: begin
        sample_en = 1'b1;
        state_nxt = S_DWELL;
      end
      S_DWELL: begin
        if (c_q == CW'(COL_CYCLES - 1)) begin
          c_nxt     = '0;
          state_nxt = S_DRIVE;
          if (k_q == KW'(COLS - 1)) begin
            k_nxt     = '0;
            frame_end = 1'b1;
          end else begin
            k_nxt = k_q + KW'(1);
          end
        end
      end
      default: state_nxt = S_DRIVE;
    endcase
    // Column 0 sits on the MSB pin.
    col_drive = '1;
    for (int i = 0; i < COLS; i++)
      if (k_nxt == KW'(COLS - 1 - i)) col_drive[i] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_s1 <= '1;
      rows_s2 <= '1;
      state   <= S_DRIVE;
      c_q     <= '0;
      k_q     <= '0;
      cols_q  <= '1;
      frame_q <= '0;
    end else begin
      rows_s1 <= kp.Rows;
      rows_s2 <= rows_s1;
      state   <= state_nxt;
      c_q     <= c_nxt;
      k_q     <= k_nxt;
      cols_q  <= col_drive;
      if (sample_en)
        for (int r = 0; r < ROWS; r++)
          for (int j = 0; j < COLS; j++)
            if (k_q == KW'(j)) frame_q[r*COLS+j] <= rows_act[ROWS-1-r];
    end
  end

  keypad_debounce #(
    .ROWS(ROWS), .COLS(COLS), .DEBOUNCE_SCANS(DEBOUNCE_SCANS), .KEYW(KEYW)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame      (frame_q),
    .frame_end  (frame_end),
    .key_value  (kp.keyValue),
    .key_pressed(kp.keyPressed),
    .key_event  (kp.keyEvent),
    .multi_key  (kp.multiKey)
  );
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 switch-matrix model and a 64-cycle frame.
module tb_keypad_scanner;
  localparam int ROWS = 4, COLS = 4, COL_CYCLES = 16, SETTLE_CYCLES = 4, DEBOUNCE_SCANS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kif ();

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .COL_CYCLES(COL_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kif)
  );

  // Switch matrix: a pressed key pulls its row low while its column is driven.
  logic [15:0] keys = '0;
  logic [3:0]  rows_drv;
  always_comb begin
    rows_drv = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (kif.Cols[3-c] == 1'b0)) rows_drv[3-r] = 1'b0;
  end
  assign kif.Rows = rows_drv;

  int total = 0, bad = 0;
  int ev_cnt = 0, width_err = 0;
  logic ev_prev = 1'b0;

  always @(negedge clk) begin
    if (kif.keyEvent) begin
      ev_cnt <= ev_cnt + 1;
      if (ev_prev) width_err <= width_err + 1;
    end
    ev_prev <= kif.keyEvent;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_frame_start();
    int n;
    n = 0;
    while (kif.Cols == 4'b0111 && n < 200) begin tick(); n++; end
    while (kif.Cols != 4'b0111 && n < 200) begin tick(); n++; end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL frame_start: waited %0d cycles, required < 200", n);
    end
  endtask

  task automatic test_reset();
    int cols_err, out_err, k;
    logic [3:0] exp_cols;
    rst = 1'b1; keys = '0;
    tick_n(3);
    total++; if (kif.Cols !== 4'b1111) begin bad++; $display("FAIL rst_cols: got %b want 1111", kif.Cols); end
    total++; if (kif.keyValue !== 4'd0) begin bad++; $display("FAIL rst_keyValue: got %0d want 0", kif.keyValue); end
    total++; if (kif.keyPressed !== 1'b0) begin bad++; $display("FAIL rst_keyPressed: got %b want 0", kif.keyPressed); end
    total++; if (kif.keyEvent !== 1'b0) begin bad++; $display("FAIL rst_keyEvent: got %b want 0", kif.keyEvent); end
    total++; if (kif.multiKey !== 1'b0) begin bad++; $display("FAIL rst_multiKey: got %b want 0", kif.multiKey); end
    rst = 1'b0;
    cols_err = 0; out_err = 0;
    for (int m = 1; m <= 192; m++) begin
      tick();
      k = (m / 16) % 4;
      exp_cols = ~(4'b1000 >> k);
      if (kif.Cols !== exp_cols) cols_err++;
      if (kif.keyValue !== 4'd0 || kif.keyPressed !== 1'b0 ||
          kif.keyEvent !== 1'b0 || kif.multiKey !== 1'b0) out_err++;
      if (m == 1) begin
        total++; if (kif.Cols !== 4'b0111) begin bad++; $display("FAIL first_drive: got %b want 0111", kif.Cols); end
      end
      if (m == 16) begin
        total++; if (kif.Cols !== 4'b1011) begin bad++; $display("FAIL col1_drive: got %b want 1011", kif.Cols); end
      end
    end
    total++; if (cols_err !== 0) begin bad++; $display("FAIL idle_cols_seq: got %0d wrong cycles want 0", cols_err); end
    total++; if (out_err !== 0) begin bad++; $display("FAIL idle_outputs: got %0d nonzero cycles want 0", out_err); end
  endtask

  task automatic test_hold();
    int e0;
    wait_frame_start();
    e0 = ev_cnt;
    keys = 16'h0040;
    tick_n(132);
    total++; if (ev_cnt !== e0) begin bad++; $display("FAIL hold_early_event: got %0d want %0d", ev_cnt, e0); end
    total++; if (kif.keyPressed !== 1'b0) begin bad++; $display("FAIL hold_early_pressed: got %b want 0", kif.keyPressed); end
    tick_n(64);
    total++; if (ev_cnt !== e0 + 1) begin bad++; $display("FAIL hold_event: got %0d want %0d", ev_cnt, e0 + 1); end
    total++; if (kif.keyValue !== 4'd6) begin bad++; $display("FAIL hold_keyValue: got %0d want 6", kif.keyValue); end
    total++; if (kif.keyPressed !== 1'b1) begin bad++; $display("FAIL hold_pressed: got %b want 1", kif.keyPressed); end
    total++; if (kif.multiKey !== 1'b0) begin bad++; $display("FAIL hold_multi: got %b want 0", kif.multiKey); end
    tick_n(128);
    total++; if (ev_cnt !== e0 + 1) begin bad++; $display("FAIL hold_repeat: got %0d want %0d", ev_cnt, e0 + 1); end
  endtask

  task automatic test_release();
    int e0;
    wait_frame_start();
    e0 = ev_cnt;
    keys = '0;
    tick_n(132);
    total++; if (kif.keyPressed !== 1'b1) begin bad++; $display("FAIL rel_early_pressed: got %b want 1", kif.keyPressed); end
    tick_n(64);
    total++; if (kif.keyPressed !== 1'b0) begin bad++; $display("FAIL rel_pressed: got %b want 0", kif.keyPressed); end
    total++; if (kif.keyValue !== 4'd6) begin bad++; $display("FAIL rel_keyValue: got %0d want 6", kif.keyValue); end
    total++; if (ev_cnt !== e0) begin bad++; $display("FAIL rel_event: got %0d want %0d", ev_cnt, e0); end
  endtask

  task automatic test_bounce();
    int e0;
    wait_frame_start();
    e0 = ev_cnt;
    tick_n(10);
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      tick_n(20);
    end
    keys = 16'h0040;
    tick_n(66);
    total++; if (ev_cnt !== e0) begin bad++; $display("FAIL bounce_early_event: got %0d want %0d", ev_cnt, e0); end
    total++; if (kif.keyPressed !== 1'b0) begin bad++; $display("FAIL bounce_early_pressed: got %b want 0", kif.keyPressed); end
    tick_n(64);
    total++; if (ev_cnt !== e0 + 1) begin bad++; $display("FAIL bounce_event: got %0d want %0d", ev_cnt, e0 + 1); end
    total++; if (kif.keyValue !== 4'd6) begin bad++; $display("FAIL bounce_keyValue: got %0d want 6", kif.keyValue); end
    total++; if (kif.keyPressed !== 1'b1) begin bad++; $display("FAIL bounce_pressed: got %b want 1", kif.keyPressed); end
  endtask

  task automatic test_multi();
    int e0, e1;
    wait_frame_start();
    e0 = ev_cnt;
    keys = 16'h8001;
    tick_n(196);
    total++; if (kif.multiKey !== 1'b1) begin bad++; $display("FAIL multi_flag: got %b want 1", kif.multiKey); end
    total++; if (kif.keyPressed !== 1'b0) begin bad++; $display("FAIL multi_pressed: got %b want 0", kif.keyPressed); end
    total++; if (kif.keyValue !== 4'd6) begin bad++; $display("FAIL multi_keyValue: got %0d want 6", kif.keyValue); end
    total++; if (ev_cnt !== e0) begin bad++; $display("FAIL multi_event: got %0d want %0d", ev_cnt, e0); end
    wait_frame_start();
    e1 = ev_cnt;
    keys = 16'h0001;
    tick_n(132);
    total++; if (kif.multiKey !== 1'b1) begin bad++; $display("FAIL multi_hold_flag: got %b want 1", kif.multiKey); end
    tick_n(64);
    total++; if (ev_cnt !== e1 + 1) begin bad++; $display("FAIL single_event: got %0d want %0d", ev_cnt, e1 + 1); end
    total++; if (kif.keyValue !== 4'd0) begin bad++; $display("FAIL single_keyValue: got %0d want 0", kif.keyValue); end
    total++; if (kif.multiKey !== 1'b0) begin bad++; $display("FAIL single_multi: got %b want 0", kif.multiKey); end
    total++; if (kif.keyPressed !== 1'b1) begin bad++; $display("FAIL single_pressed: got %b want 1", kif.keyPressed); end
  endtask

  task automatic test_switch();
    int e0;
    wait_frame_start();
    e0 = ev_cnt;
    keys = 16'h0020;
    tick_n(196);
    total++; if (ev_cnt !== e0 + 1) begin bad++; $display("FAIL sw5_event: got %0d want %0d", ev_cnt, e0 + 1); end
    total++; if (kif.keyValue !== 4'd5) begin bad++; $display("FAIL sw5_keyValue: got %0d want 5", kif.keyValue); end
    wait_frame_start();
    keys = 16'h0400;
    tick_n(196);
    total++; if (ev_cnt !== e0 + 2) begin bad++; $display("FAIL sw10_event: got %0d want %0d", ev_cnt, e0 + 2); end
    total++; if (kif.keyValue !== 4'd10) begin bad++; $display("FAIL sw10_keyValue: got %0d want 10", kif.keyValue); end
    total++; if (kif.keyPressed !== 1'b1) begin bad++; $display("FAIL sw10_pressed: got %b want 1", kif.keyPressed); end
  endtask

  task automatic test_reset_mid();
    int e0, e1;
    wait_frame_start();
    e0 = ev_cnt;
    keys = 16'h0040;
    tick_n(196);
    total++; if (kif.keyValue !== 4'd6) begin bad++; $display("FAIL pre_rst_keyValue: got %0d want 6", kif.keyValue); end
    tick_n(20);
    e1 = ev_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (kif.keyValue !== 4'd0) begin bad++; $display("FAIL mid_rst_keyValue: got %0d want 0", kif.keyValue); end
    total++; if (kif.keyPressed !== 1'b0) begin bad++; $display("FAIL mid_rst_pressed: got %b want 0", kif.keyPressed); end
    total++; if (kif.Cols !== 4'b1111) begin bad++; $display("FAIL mid_rst_cols: got %b want 1111", kif.Cols); end
    total++; if (kif.keyEvent !== 1'b0) begin bad++; $display("FAIL mid_rst_event: got %b want 0", kif.keyEvent); end
    tick_n(188);
    total++; if (ev_cnt !== e1) begin bad++; $display("FAIL post_rst_early_event: got %0d want %0d", ev_cnt, e1); end
    total++; if (kif.keyPressed !== 1'b0) begin bad++; $display("FAIL post_rst_early_pressed: got %b want 0", kif.keyPressed); end
    tick_n(8);
    total++; if (ev_cnt !== e1 + 1) begin bad++; $display("FAIL post_rst_event: got %0d want %0d", ev_cnt, e1 + 1); end
    total++; if (kif.keyValue !== 4'd6) begin bad++; $display("FAIL post_rst_keyValue: got %0d want 6", kif.keyValue); end
    total++; if (kif.keyPressed !== 1'b1) begin bad++; $display("FAIL post_rst_pressed: got %b want 1", kif.keyPressed); end
  endtask

  task automatic test_pulse_width();
    total++;
    if (width_err !== 0) begin bad++; $display("FAIL event_width: got %0d multi-cycle pulses want 0", width_err); end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_release();
    test_bounce();
    test_multi();
    test_switch();
    test_reset_mid();
    test_pulse_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner that succeeds the fixed 4x4 scanner. It drives one active-low column at a time and samples synchronised active-low rows into a full-frame key bitmap. Frames are debounced across consecutive scans, and the block reports a single held key, a one-cycle press event and a multi-key (ghosting) flag. It sits between the board keypad pins and the game input logic (arrow/step decoding).

## Interface
Parameters:
- `ROWS`, 4: number of row inputs (≥2).
- `COLS`, 4: number of column outputs (≥2).
- `COL_CYCLES`, 100000: clock cycles each column is driven; 1 ms at 100 MHz. Must be > `SETTLE_CYCLES`+1.
- `SETTLE_CYCLES`, 8: cycles from column drive to row sample. Must be ≥3.
- `DEBOUNCE_SCANS`, 3: identical consecutive frames required to accept a frame (≥1).
- `KEYW`, `$clog2(ROWS*COLS)`: key index width (derived, not overridden).

Ports:
- `clk` input 1: system clock. One clock domain only.
- `rst` input 1: synchronous, active-high reset.
- `Rows` input ROWS: keypad rows, active-low, asynchronous to `clk`.
- `Cols` output COLS: column drive, one-cold. Column k driven means `Cols[COLS-1-k]`=0, so column 0 is the MSB, matching pin order.
- `keyValue` output KEYW: row-major index of the accepted key, row*COLS + col. Row r is `Rows[ROWS-1-r]`.
- `keyPressed` output 1: level, high while exactly one key is accepted.
- `keyEvent` output 1: one-cycle pulse on a newly accepted single key.
- `multiKey` output 1: level, high while the accepted frame has ≥2 keys.

## Operation
- `Rows` passes through a 2-flop synchroniser and is inverted to active-high before use.
- Scan FSM states:
  - DRIVE: `Cols` drives column k; cycle counter c runs 0..COL_CYCLES-1.
  - SAMPLE: one cycle, at c==SETTLE_CYCLES. Captures the synced rows into frame bits [r*COLS+k].
  - DWELL: runs until c==COL_CYCLES-1, then k advances.
  - k wraps COLS-1 → 0, ending the frame.
- Frame end happens at k==COLS-1, c==COL_CYCLES-1. On that edge the new frame bitmap is compared with the previous frame:
  - Equal: stable counter increments, saturating at DEBOUNCE_SCANS-1.
  - Different: stable counter is cleared to 0.
- Acceptance: the frame is accepted when the stable count reaches DEBOUNCE_SCANS-1 and the frame differs from the currently accepted frame. Re-acceptance of the same frame has no effect. With DEBOUNCE_SCANS=1, every frame that differs from the accepted frame is accepted immediately.
- Classification of an accepted frame:
  - 0 bits set: `keyPressed`=0, `multiKey`=0, `keyValue` holds its last value.
  - 1 bit set: `keyPressed`=1, `multiKey`=0, `keyValue`=index, `keyEvent` pulses.
  - ≥2 bits set: `keyPressed`=0, `multiKey`=1, `keyValue` holds, no event.
- Key-to-key change (A released and B pressed within one debounce window): accepting B produces a new `keyEvent`.
- Partial-frame glitches never reach the outputs. Only whole frames are classified.

## Timing
- Reset values:
  - `Cols` all ones.
  - `keyValue`=0, `keyPressed`=0, `keyEvent`=0, `multiKey`=0.
  - k=0, c=0, both frame registers=0, stable count=0, synchroniser=all ones.
- First edge with `rst`=0: `Cols` drives column 0.
- Frame period is COLS*COL_CYCLES cycles.
- Outputs update on the frame-end edge. They are visible the cycle after that edge, so press-to-event latency is at most (DEBOUNCE_SCANS+1) frames.
- `keyEvent` is high for exactly one cycle.
- `rst` asserted mid-frame aborts the scan and returns every register to its reset value on that edge. No event is generated.
- Row changes arriving ≤2 cycles before SAMPLE may be missed in that frame. They are caught in the next frame.

## Structure
- Package `keypad_pkg` holds:
  - default parameter constants;
  - the FSM state enum (DRIVE/SAMPLE/DWELL);
  - function `key_index(row, col, cols)`;
  - popcount-class function returning NONE/ONE/MULTI.
- Sub-module `keypad_debounce`: frame compare, stable counter, acceptance and classification. Its inputs are the frame bitmap and a frame-end strobe.
- The top level keeps the synchroniser, scan FSM and column drive.

## Test plan
Bench parameters: ROWS=4, COLS=4, COL_CYCLES=16, SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, giving a 64-cycle frame.
- Reset, then idle: `Cols` cycles 0111→1011→1101→1110, 16 cycles each; all outputs stay 0.
- Hold key row1/col2 (Rows=1011 while Cols=1101): `keyEvent` pulses once after the 3rd identical frame; `keyValue`=6, `keyPressed`=1 held. Release: `keyPressed`=0 after 3 frames, `keyValue` stays 6.
- Key bounces every 20 cycles for 2 frames, then holds: no event during bounce; exactly one event at 3 stable frames after the bounce ends.
- Keys 0 and 15 held together: `multiKey`=1, `keyPressed`=0, no event. Release key 15: event with `keyValue`=0.
- Key 5 held, then switched directly to key 10: second `keyEvent` with `keyValue`=10.
- `rst` pulsed mid-frame while key 6 is held: outputs clear on the reset edge; the event re-fires 3 frames after `rst` deasserts.
